serial_adder: RTL
=================

Name: serial_adder

Overview:
Bit-serial N-bit adder, the additive counterpart to the team's subtractor cells. It latches two operands and a carry-in on a start handshake. One bit is processed per clock, LSB first, through a single full-adder cell and a carry flip-flop. It presents the sum, carry-out and a one-cycle done pulse, and serves area-constrained datapaths where WIDTH cycles of latency are acceptable.

Parameters:
WIDTH, 8, operand and sum width in bits (legal range 2..32).

Ports:
clk  input  1  system clock; all state updates on rising edge.
rst  input  1  synchronous, active-high reset; sampled on the rising edge of clk.
start  input  1  request a new addition; honoured only when busy=0.
X  input  WIDTH  operand A; sampled only on an accepted start.
Y  input  WIDTH  operand B; sampled only on an accepted start.
CI  input  1  carry-in; sampled only on an accepted start.
busy  output  1  high while an addition is in progress (RUN state).
done  output  1  one-cycle pulse when S/CO become valid.
S  output  WIDTH  sum; valid from the done cycle, held until the next accepted start.
CO  output  1  carry-out of the MSB; same validity as S.

Behaviour:
- Clock/reset: one clock (clk); reset is synchronous and active-high (rst).
- Reset values: state=IDLE, busy=0, done=0, S=0, CO=0, bit counter=0, operand and carry registers=0.
- rst has priority over every other input, including mid-RUN. A reset during RUN aborts the addition, no done is emitted, and all outputs return to their reset values on the next edge.
- States:
  - IDLE: busy=0, done=0. start=1 moves to RUN.
  - RUN: busy=1, done=0. One bit is processed per cycle. After the WIDTH-th bit, moves to DONE.
  - DONE: busy=0, done=1 for exactly one cycle. start=1 moves to RUN (back-to-back accepted); otherwise moves to IDLE.
- Accepted start (busy=0 and start=1) on edge k:
  - The X and Y shift registers load X and Y.
  - The carry flop loads CI.
  - The counter clears.
  - S is cleared to 0 and CO to 0; previous results are not held past an accepted start.
- Each RUN cycle:
  - sum bit = a0 ^ b0 ^ c; new c = (a0 & b0) | (c & (a0 ^ b0)), where a0/b0 are the LSBs of the operand shift registers.
  - Both operand registers shift right by 1, zero-filled.
  - The sum bit enters S at the MSB while S shifts right. After WIDTH shifts, S holds the full result in natural order.
  - The counter increments.
- End of RUN: on the edge where counter = WIDTH-1, CO <= new c and the state becomes DONE.
- Latency: start sampled on edge k -> done=1 during the cycle after edge k+WIDTH. That is WIDTH+1 cycles from the start edge to the done edge (9 for WIDTH=8).
- start while busy=1 is ignored; operands and progress are unaffected.
- Arithmetic: {CO,S} = X + Y + CI, modulo 2^(WIDTH+1). There is no overflow flag; unsigned semantics.
- Inputs X/Y/CI may change freely after the accepted start edge without effect.
- Counter width: $clog2(WIDTH).

Decomposition:
- Shared package (adder_pkg):
  - state encoding constants ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2 (2'd3 illegal; decodes to IDLE).
  - function cnt_w(WIDTH) returning the counter width.
- One natural sub-module: full_adder_cell, purely combinational (inputs a, b, cin; outputs s, cout). It is instantiated once for the bit-serial datapath.
- FSM, shift registers, carry flop and counter live in serial_adder itself.

Test Plan:
1. rst=1 for 2 cycles, then rst=0 idle -> S=0x00, CO=0, busy=0, done=0.
2. WIDTH=8, start with X=0x3C, Y=0x25, CI=0 -> busy high for 8 cycles, done pulse 9 cycles after start, S=0x61, CO=0.
3. X=0xFF, Y=0x01, CI=0 -> S=0x00, CO=1. Then X=0xFF, Y=0xFF, CI=1 -> S=0xFF, CO=1.
4. start with X=0x10, Y=0x20, then pulse start with X=0xAA, Y=0x55 during RUN cycle 3 -> ignored; result S=0x30, CO=0, one done pulse only.
5. start with X=0x7F, Y=0x01, assert rst in RUN cycle 4 -> no done, outputs zero next edge. A subsequent start with X=0x01, Y=0x02 gives S=0x03.
6. Back-to-back: start held high through the DONE cycle with new X=0x80, Y=0x80 -> first result observable for the one done cycle; second result S=0x00, CO=1 with done 9 cycles later.

Source files
------------

// File: rtl/adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding and the
// helper that sizes the bit counter.
// Ports: none (package only).
package adder_pkg;

  // ST_IDLE=0, ST_RUN=1, ST_DONE=2. The unused code 2'd3 is treated as IDLE.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // The counter must hold 0..WIDTH-1. A minimum of 1 bit keeps the vector legal.
  function automatic int cnt_w(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/full_adder_cell.sv
// One-bit full adder, purely combinational.
// Ports: a, b, cin (addend bits and carry in); s (sum bit), cout (carry out).
module full_adder_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: {CO,S} = X + Y + CI, one bit per clock, LSB first.
// Ports: clk, rst (sync, active-high); start/X/Y/CI request a new addition;
//        busy (RUN in progress), done (1-cycle pulse), S/CO result.
module serial_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] X,
  input  logic [WIDTH-1:0] Y,
  input  logic             CI,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] S,
  output logic             CO
);

  localparam int            CW   = cnt_w(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             c_q;
  logic [CW-1:0]    cnt;

  logic fa_s;
  logic fa_cout;

  full_adder_cell u_fa (
    .a    (a_q[0]),
    .b    (b_q[0]),
    .cin  (c_q),
    .s    (fa_s),
    .cout (fa_cout)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      S     <= '0;
      CO    <= 1'b0;
      cnt   <= '0;
      a_q   <= '0;
      b_q   <= '0;
      c_q   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_RUN: begin
          a_q <= a_q >> 1;
          b_q <= b_q >> 1;
          c_q <= fa_cout;
          // Sum bits enter at the MSB. After WIDTH shifts the bits are in natural order.
          S   <= {fa_s, S[WIDTH-1:1]};
          cnt <= cnt + CW'(1);
          if (cnt == LAST) begin
            CO    <= fa_cout;
            state <= ST_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        // IDLE, DONE and the illegal encoding all behave as IDLE. DONE also
        // lasts only one cycle and accepts a back-to-back start.
        default: begin
          if (start) begin
            a_q   <= X;
            b_q   <= Y;
            c_q   <= CI;
            cnt   <= '0;
            S     <= '0;
            CO    <= 1'b0;
            state <= ST_RUN;
            busy  <= 1'b1;
          end else begin
            state <= ST_IDLE;
          end
        end
      endcase
    end
  end

endmodule
